// File: rtl/timecode_pkg.sv
// Shared symbol encoding constants and FSM state type for the display-word decoder.
package timecode_pkg;

  localparam int SYM_W = 5;
  localparam logic [SYM_W-1:0] SYM_OFF     = 5'd20;
  localparam logic [SYM_W-1:0] SYM_DP_BASE = 5'd10;
  localparam logic [SYM_W-1:0] SYM_MAX     = 5'd20;

  // Display word shown by the timer after reset: "  0.000".
  localparam logic [6*SYM_W-1:0] DISPLAY_ZERO = {5'd20, 5'd20, 5'd10, 5'd0, 5'd0, 5'd0};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/timecode_sym_decode.sv
// Combinational classification of one 5-bit display symbol into digit value,
// decimal-point flag, blank flag and invalid-code flag.
module timecode_sym_decode
  import timecode_pkg::*;
(
  input  logic [SYM_W-1:0] sym,
  output logic [3:0]       digit,
  output logic             has_dp,
  output logic             is_off,
  output logic             is_invalid
);

  // Map code ranges: 0..9 plain digit, 10..19 digit with point, 20 blank, above that invalid.
  always_comb begin
    digit      = 4'd0;
    has_dp     = 1'b0;
    is_off     = 1'b0;
    is_invalid = 1'b0;
    if (sym < SYM_DP_BASE) begin
      digit = sym[3:0];
    end else if (sym < SYM_OFF) begin
      digit  = 4'(sym - SYM_DP_BASE);
      has_dp = 1'b1;
    end else if (sym == SYM_OFF) begin
      is_off = 1'b1;
    end else begin
      is_invalid = (sym > SYM_MAX);
    end
  end

endmodule

// File: rtl/timecode_decoder.sv
// Sequential decoder from a six-symbol display word back to a binary millisecond
// count, one symbol per clock MSB first, with well-formedness checking.
module timecode_decoder
  import timecode_pkg::*;
#(
  parameter int DIGITS = 6,
  parameter int DP_POS = 3,
  parameter int CNT_W  = 20
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [SYM_W*DIGITS-1:0]  time_in,
  output logic                     busy,
  output logic                     done,
  output logic [CNT_W-1:0]         ms_count,
  output logic                     err_invalid,
  output logic                     err_dp,
  output logic                     err_blank
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int WORD_W = SYM_W * DIGITS;

  state_e             state_q, state_d;
  logic [WORD_W-1:0]  shreg_q, shreg_d;
  logic [CNT_W-1:0]   acc_q, acc_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               lead_q, lead_d;
  logic               acc_inv_q, acc_inv_d;
  logic               acc_dp_q, acc_dp_d;
  logic               acc_blank_q, acc_blank_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   ms_count_q, ms_count_d;
  logic               err_invalid_q, err_invalid_d;
  logic               err_dp_q, err_dp_d;
  logic               err_blank_q, err_blank_d;

  logic [SYM_W-1:0]   sym_s;
  logic [3:0]         digit_s;
  logic               has_dp_s;
  logic               is_off_s;
  logic               is_invalid_s;
  logic [CNT_W-1:0]   acc_step_s;
  logic               inv_step_s;
  logic               dp_step_s;
  logic               blank_step_s;
  logic               at_dp_s;
  logic               load_s;

  assign sym_s = shreg_q[WORD_W-1 -: SYM_W];

  timecode_sym_decode u_sym (
    .sym        (sym_s),
    .digit      (digit_s),
    .has_dp     (has_dp_s),
    .is_off     (is_off_s),
    .is_invalid (is_invalid_s)
  );

  // Per-symbol datapath: accumulate the digit and fold in this symbol's error checks.
  always_comb begin
    at_dp_s      = (idx_q == IDX_W'(DP_POS));
    acc_step_s   = (acc_q << 3) + (acc_q << 1) + CNT_W'(digit_s);
    inv_step_s   = acc_inv_q | is_invalid_s;
    dp_step_s    = acc_dp_q | (at_dp_s ? !has_dp_s : has_dp_s);
    blank_step_s = acc_blank_q | (is_off_s & (!lead_q | (idx_q <= IDX_W'(DP_POS))));
  end

  // Next-state and output logic; a new word is accepted from IDLE or straight from DONE.
  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    acc_d         = acc_q;
    idx_d         = idx_q;
    lead_d        = lead_q;
    acc_inv_d     = acc_inv_q;
    acc_dp_d      = acc_dp_q;
    acc_blank_d   = acc_blank_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    ms_count_d    = ms_count_q;
    err_invalid_d = err_invalid_q;
    err_dp_d      = err_dp_q;
    err_blank_d   = err_blank_q;
    load_s        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        load_s = start;
      end
      ST_DECODE: begin
        acc_d       = acc_step_s;
        shreg_d     = shreg_q << SYM_W;
        lead_d      = lead_q & is_off_s;
        acc_inv_d   = inv_step_s;
        acc_dp_d    = dp_step_s;
        acc_blank_d = blank_step_s;
        idx_d       = idx_q - IDX_W'(1);
        if (idx_q == IDX_W'(0)) begin
          state_d       = ST_DONE;
          busy_d        = 1'b0;
          done_d        = 1'b1;
          err_invalid_d = inv_step_s;
          err_dp_d      = dp_step_s;
          err_blank_d   = blank_step_s;
          ms_count_d    = (inv_step_s | dp_step_s | blank_step_s) ? '0 : acc_step_s;
        end else begin
          state_d = ST_DECODE;
        end
      end
      ST_DONE: begin
        load_s  = start;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (load_s) begin
      state_d     = ST_DECODE;
      busy_d      = 1'b1;
      shreg_d     = time_in;
      acc_d       = '0;
      idx_d       = IDX_W'(DIGITS - 1);
      lead_d      = 1'b1;
      acc_inv_d   = 1'b0;
      acc_dp_d    = 1'b0;
      acc_blank_d = 1'b0;
    end else begin
      lead_d = lead_d;
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      shreg_q       <= '0;
      acc_q         <= '0;
      idx_q         <= '0;
      lead_q        <= 1'b0;
      acc_inv_q     <= 1'b0;
      acc_dp_q      <= 1'b0;
      acc_blank_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      ms_count_q    <= '0;
      err_invalid_q <= 1'b0;
      err_dp_q      <= 1'b0;
      err_blank_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      acc_q         <= acc_d;
      idx_q         <= idx_d;
      lead_q        <= lead_d;
      acc_inv_q     <= acc_inv_d;
      acc_dp_q      <= acc_dp_d;
      acc_blank_q   <= acc_blank_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      ms_count_q    <= ms_count_d;
      err_invalid_q <= err_invalid_d;
      err_dp_q      <= err_dp_d;
      err_blank_q   <= err_blank_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign ms_count    = ms_count_q;
  assign err_invalid = err_invalid_q;
  assign err_dp      = err_dp_q;
  assign err_blank   = err_blank_q;

endmodule

// File: tb/tb_timecode_decoder.sv
// Scoreboard bench for timecode_decoder: stimulus pushes expected results, a
// negedge monitor pops and compares on every done pulse.
module tb_timecode_decoder;

  logic        clk;
  logic        reset;
  logic        start;
  logic [29:0] time_in;
  logic        busy;
  logic        done;
  logic [19:0] ms_count;
  logic        err_invalid;
  logic        err_dp;
  logic        err_blank;

  typedef struct packed {
    logic [19:0] ms;
    logic        inv;
    logic        dp;
    logic        blk;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   done_seen = 0;

  timecode_decoder #(.DIGITS(6), .DP_POS(3), .CNT_W(20)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .time_in     (time_in),
    .busy        (busy),
    .done        (done),
    .ms_count    (ms_count),
    .err_invalid (err_invalid),
    .err_dp      (err_dp),
    .err_blank   (err_blank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [29:0] w(int s5, int s4, int s3, int s2, int s1, int s0);
    return {5'(s5), 5'(s4), 5'(s3), 5'(s2), 5'(s1), 5'(s0)};
  endfunction

  function automatic exp_t mk(int ms, bit inv, bit dp, bit blk);
    exp_t e;
    e.ms  = 20'(ms);
    e.inv = inv;
    e.dp  = dp;
    e.blk = blk;
    return e;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      exp_t e;
      done_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done ms_count=%0d at %0t", ms_count, $time);
      end else begin
        e = exp_q.pop_front();
        check("ms_count", 32'(ms_count), 32'(e.ms));
        check("err_invalid", 32'(err_invalid), 32'(e.inv));
        check("err_dp", 32'(err_dp), 32'(e.dp));
        check("err_blank", 32'(err_blank), 32'(e.blk));
        check("busy_in_done", 32'(busy), 32'd0);
      end
    end
  end

  task automatic decode(logic [29:0] word, exp_t e);
    int lat;
    lat = 0;
    @(negedge clk);
    start   = 1'b1;
    time_in = word;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    start   = 1'b0;
    time_in = 30'h3FFF_FFFF;
    check("busy_after_accept", 32'(busy), 32'd1);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    check("done_latency_edges", 32'(lat), 32'd6);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic check_cleared(string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_ms"}, 32'(ms_count), 32'd0);
    check({tag, "_flags"}, 32'({err_invalid, err_dp, err_blank}), 32'd0);
  endtask

  initial begin
    int dones_before;
    reset   = 1'b1;
    start   = 1'b0;
    time_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check_cleared("reset");
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_cleared("idle_after_reset");

    decode(w(20, 20, 10, 0, 0, 0), mk(0, 0, 0, 0));
    decode(w(1, 2, 13, 4, 5, 6), mk(123456, 0, 0, 0));
    decode(w(9, 9, 19, 9, 9, 9), mk(999999, 0, 0, 0));
    decode(w(20, 20, 11, 2, 3, 21), mk(0, 1, 0, 0));
    decode(w(20, 20, 1, 2, 3, 4), mk(0, 0, 1, 0));
    decode(w(1, 20, 10, 0, 0, 0), mk(0, 0, 0, 1));
    decode(w(20, 20, 20, 10, 0, 0), mk(0, 0, 1, 1));
    decode(w(0, 0, 10, 0, 0, 1), mk(1, 0, 0, 0));

    // Back-to-back: start held high, time_in scrambled except during the DONE cycle.
    dones_before = done_seen;
    @(negedge clk);
    start   = 1'b1;
    time_in = w(20, 20, 17, 0, 4, 2);
    exp_q.push_back(mk(7042, 0, 0, 0));
    exp_q.push_back(mk(314159, 0, 0, 0));
    for (int e = 0; e <= 13; e++) begin
      @(posedge clk);
      #1;
      time_in = (e == 6) ? w(3, 1, 14, 1, 5, 9) : w(e % 10, 9, 1, 2, 20, 4);
      if (e == 6) check("b2b_done_first", 32'(done), 32'd1);
      if (e == 13) begin
        check("b2b_done_second", 32'(done), 32'd1);
        start = 1'b0;
      end
    end
    repeat (12) @(posedge clk);
    #1;
    check("b2b_done_count", 32'(done_seen - dones_before), 32'd2);

    // Reset during the third DECODE cycle must abort without a done pulse.
    dones_before = done_seen;
    @(negedge clk);
    start   = 1'b1;
    time_in = w(9, 9, 19, 9, 9, 9);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_cleared("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("mid_reset_no_done", 32'(done_seen - dones_before), 32'd0);
    check("mid_reset_idle", 32'(busy), 32'd0);

    decode(w(20, 5, 12, 0, 0, 7), mk(52007, 0, 0, 0));

    repeat (4) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
